// File: rtl/ntt_in_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : ntt_in_framer_if
// Brief    : Command, raw source and framed sink stream bundle for the framer.
// Revision : 1.0 - initial release
// ============================================================================
interface ntt_in_framer_if #(
  parameter int pDATA_WIDTH = 32
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [1:0]                 cmd_mode;

  logic                       src_tvalid;
  logic                       src_tready;
  logic [pDATA_WIDTH-1:0]     src_tdata;
  logic                       src_tlast;

  logic                       ss_tvalid;
  logic                       ss_tready;
  logic [pDATA_WIDTH-1:0]     ss_tdata;
  logic                       ss_tlast;
  logic [1:0]                 ss_tuser;
  logic [pDATA_WIDTH/8-1:0]   ss_tstrb;
  logic [pDATA_WIDTH/8-1:0]   ss_tkeep;

  // Framer side: consumes command and source, produces the framed stream.
  modport master (
    input  cmd_valid, cmd_mode,
    input  src_tvalid, src_tdata, src_tlast,
    input  ss_tready,
    output cmd_ready, src_tready,
    output ss_tvalid, ss_tdata, ss_tlast, ss_tuser, ss_tstrb, ss_tkeep
  );

  // Environment side: issues commands, supplies source data, sinks the frame.
  modport slave (
    output cmd_valid, cmd_mode,
    output src_tvalid, src_tdata, src_tlast,
    output ss_tready,
    input  cmd_ready, src_tready,
    input  ss_tvalid, ss_tdata, ss_tlast, ss_tuser, ss_tstrb, ss_tkeep
  );
endinterface
`default_nettype wire

// File: rtl/ntt_in_framer.sv
`default_nettype none
// ============================================================================
// Module   : ntt_in_framer
// Brief    : Frames one mode command plus raw source data into the NTT ss_*
//            stream: header word, fixed-length payload, tlast on final beat.
//            Define NTT_FRAMER_ERR_EN to check src_tlast placement into err.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_in_framer #(
  parameter int pDATA_WIDTH = 32,
  parameter int pF_WORDS    = 2048,
  parameter int pU_WORDS    = 1024,
  parameter int pCNT_W      = 12
) (
  input  wire logic              axis_clk,
  input  wire logic              axis_rst_n,
  ntt_in_framer_if.master        bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err,
  output logic [pCNT_W-1:0]      beat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HDR   = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [pCNT_W-1:0] c_F_LEN = pCNT_W'(pF_WORDS);
  localparam logic [pCNT_W-1:0] c_U_LEN = pCNT_W'(pU_WORDS);
  localparam logic [pCNT_W-1:0] c_ONE   = pCNT_W'(1);

  state_t                 r_state;
  logic [pCNT_W-1:0]      r_len;
  logic [pCNT_W-1:0]      r_idx;
  logic [pCNT_W-1:0]      r_beat;
  logic [pDATA_WIDTH-1:0] r_tdata;
  logic                   r_tlast;
  logic                   r_tvalid;
  logic                   r_done;

  logic w_load_ok;
  logic w_src_ready;
  logic w_src_fire;
  logic w_ss_fire;
  logic w_cmd_fire;
  logic w_last_idx;

  // The output register may take a new beat when empty or being drained.
  assign w_load_ok   = !r_tvalid || bus.ss_tready;
  assign w_src_ready = (r_state == S_DATA) && w_load_ok;
  assign w_src_fire  = bus.src_tvalid && w_src_ready;
  assign w_ss_fire   = r_tvalid && bus.ss_tready;
  assign w_cmd_fire  = bus.cmd_valid && (r_state == S_IDLE);
  assign w_last_idx  = (r_idx == r_len - c_ONE);

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_idx    <= '0;
      r_beat   <= '0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_len    <= bus.cmd_mode[1] ? c_U_LEN : c_F_LEN;
            r_tdata  <= {{(pDATA_WIDTH-4){1'b0}}, 2'b01, bus.cmd_mode};
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b1;
            r_idx    <= '0;
            r_beat   <= '0;
            r_state  <= S_HDR;
          end
        end
        S_HDR: begin
          if (bus.ss_tready) begin
            r_tvalid <= 1'b0;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_src_fire) begin
            r_tdata  <= bus.src_tdata;
            r_tlast  <= w_last_idx;
            r_tvalid <= 1'b1;
            r_idx    <= r_idx + c_ONE;
            if (w_last_idx) begin
              r_state <= S_DRAIN;
            end
          end else if (w_ss_fire) begin
            r_tvalid <= 1'b0;
          end
          if (w_ss_fire) begin
            r_beat <= r_beat + c_ONE;
          end
        end
        S_DRAIN: begin
          // Only the final payload beat is pending here.
          if (w_ss_fire) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_beat   <= r_beat + c_ONE;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef NTT_FRAMER_ERR_EN
  logic r_err;

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      r_err <= 1'b0;
    end else if (w_cmd_fire) begin
      r_err <= 1'b0;
    end else if (w_src_fire && (bus.src_tlast != w_last_idx)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_tlast;
  logic w_unused_cmd_fire;
  assign w_unused_tlast    = bus.src_tlast;
  assign w_unused_cmd_fire = w_cmd_fire;
  assign err               = 1'b0;
`endif

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign bus.src_tready = w_src_ready;
  assign bus.ss_tvalid  = r_tvalid;
  assign bus.ss_tdata   = r_tdata;
  assign bus.ss_tlast   = r_tlast;
  assign bus.ss_tuser   = 2'b00;
  assign bus.ss_tstrb   = {(pDATA_WIDTH/8){r_tvalid}};
  assign bus.ss_tkeep   = {(pDATA_WIDTH/8){r_tvalid}};
  assign busy           = (r_state != S_IDLE);
  assign frame_done     = r_done;
  assign beat_cnt       = r_beat;

endmodule
`default_nettype wire

// File: tb/tb_ntt_in_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_in_framer
// Brief    : Table-driven frame vectors plus reset/command corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_in_framer;

`ifdef NTT_FRAMER_ERR_EN
  localparam bit c_ERR_EN = 1'b1;
`else
  localparam bit c_ERR_EN = 1'b0;
`endif

  logic        axis_clk;
  logic        axis_rst_n;
  logic        busy;
  logic        frame_done;
  logic        err;
  logic [11:0] beat_cnt;

  int n_vec;
  int n_err;

  ntt_in_framer_if #(.pDATA_WIDTH(32)) bus ();

  ntt_in_framer #(
    .pDATA_WIDTH (32),
    .pF_WORDS    (2048),
    .pU_WORDS    (1024),
    .pCNT_W      (12)
  ) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .beat_cnt   (beat_cnt)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [1:0]  mode;
    int          ready_pct;
    logic [31:0] exp_hdr;
    int          exp_len;
    bit          inject_cmd;
    int          tlast_at;
    int          rst_at;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check("rst_cmd_ready",  bus.cmd_ready,  1);
    check("rst_src_tready", bus.src_tready, 0);
    check("rst_ss_tvalid",  bus.ss_tvalid,  0);
    check("rst_ss_tdata",   bus.ss_tdata,   0);
    check("rst_ss_tlast",   bus.ss_tlast,   0);
    check("rst_ss_tuser",   bus.ss_tuser,   0);
    check("rst_ss_tstrb",   bus.ss_tstrb,   0);
    check("rst_ss_tkeep",   bus.ss_tkeep,   0);
    check("rst_busy",       busy,           0);
    check("rst_frame_done", frame_done,     0);
    check("rst_err",        err,            0);
    check("rst_beat_cnt",   beat_cnt,       0);
  endtask

  task automatic run_frame(input vec_t v);
    int          sent;
    int          got;
    int          cyc;
    int          limit;
    bit          hdr_seen;
    bit          prev_stall;
    bit          exp_err;
    logic [31:0] prev_data;
    logic        prev_last;
    sent = 0; got = 0; cyc = 0; hdr_seen = 0; prev_stall = 0; exp_err = 0;
    prev_data = '0; prev_last = 1'b0;
    limit = v.exp_len * 6 + 100;

    @(negedge axis_clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_mode   = v.mode;
    bus.src_tvalid = 1'b0;
    bus.ss_tready  = 1'b0;
    #1;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge axis_clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 2'd0;
    check("hdr_valid",      bus.ss_tvalid,  1);
    check("hdr_data_early", bus.ss_tdata,   v.exp_hdr);
    check("hdr_last",       bus.ss_tlast,   0);
    check("hdr_busy",       busy,           1);
    check("hdr_src_tready", bus.src_tready, 0);
    check("hdr_done_low",   frame_done,     0);
    check("hdr_err_clear",  err,            0);
    check("hdr_beat_cnt",   beat_cnt,       0);

    while (got < v.exp_len && cyc < limit) begin
      @(negedge axis_clk);
      bus.cmd_valid = 1'b0;
      if (got == v.rst_at) begin
        axis_rst_n     = 1'b0;
        bus.src_tvalid = 1'b0;
        bus.ss_tready  = 1'b0;
        @(posedge axis_clk);
        #1;
        check_reset_state();
        axis_rst_n = 1'b1;
        return;
      end
      bus.ss_tready  = (v.ready_pct >= 100) || ($urandom_range(99, 0) < v.ready_pct);
      bus.src_tvalid = 1'b1;
      bus.src_tdata  = 32'(sent);
      bus.src_tlast  = (sent == v.tlast_at);
      if (v.inject_cmd && cyc == 200) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = ~v.mode;
      end
      #1;
      if (bus.cmd_valid) check("cmd_ignored_busy", bus.cmd_ready, 0);
      if (prev_stall) begin
        check("stall_valid", bus.ss_tvalid, 1);
        check("stall_data",  bus.ss_tdata,  prev_data);
        check("stall_last",  bus.ss_tlast,  prev_last);
      end
      check("beat_cnt", beat_cnt, got);
      check("err",      err,      exp_err);
      if (bus.ss_tvalid) begin
        check("tkeep", bus.ss_tkeep, 4'hF);
        check("tstrb", bus.ss_tstrb, 4'hF);
      end
      if (bus.ss_tvalid && bus.ss_tready) begin
        if (!hdr_seen) begin
          check("hdr_data", bus.ss_tdata, v.exp_hdr);
          hdr_seen = 1'b1;
        end else begin
          check("data",  bus.ss_tdata, got);
          check("tlast", bus.ss_tlast, (got == v.exp_len - 1));
          got++;
        end
      end
      if (sent >= v.exp_len) check("no_extra_src", bus.src_tready, 0);
      if (bus.src_tvalid && bus.src_tready) begin
        if (c_ERR_EN && (bus.src_tlast != (sent == v.exp_len - 1))) exp_err = 1'b1;
        sent++;
      end
      prev_stall = bus.ss_tvalid && !bus.ss_tready;
      prev_data  = bus.ss_tdata;
      prev_last  = bus.ss_tlast;
      cyc++;
    end

    bus.src_tvalid = 1'b0;
    bus.src_tlast  = 1'b0;
    bus.cmd_valid  = 1'b0;
    if (got < v.exp_len) check("frame_timeout", got, v.exp_len);
    @(posedge axis_clk);
    #1;
    check("done_pulse",     frame_done,    1);
    check("done_beat_cnt",  beat_cnt,      v.exp_len);
    check("done_busy",      busy,          0);
    check("done_cmd_ready", bus.cmd_ready, 1);
    check("done_tvalid",    bus.ss_tvalid, 0);
    check("done_tkeep",     bus.ss_tkeep,  0);
    check("done_err",       err,           exp_err);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //           mode   rdy%  hdr     len   inj  tlast_at rst_at
    vecs[0] = '{2'd0, 100, 32'h4, 2048, 1'b0, 2047, -1};
    vecs[1] = '{2'd3, 100, 32'h7, 1024, 1'b0, 1023, -1};
    vecs[2] = '{2'd1,  50, 32'h5, 2048, 1'b1, 2047, -1};
    vecs[3] = '{2'd0, 100, 32'h4, 2048, 1'b0, 2047, 500};
    vecs[4] = '{2'd2, 100, 32'h6, 1024, 1'b0, 1023, -1};
    vecs[5] = '{2'd2,  70, 32'h6, 1024, 1'b0, 1000, -1};
    vecs[6] = '{2'd1, 100, 32'h5, 2048, 1'b0, 2047, -1};

    axis_rst_n     = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_mode   = 2'd0;
    bus.src_tvalid = 1'b0;
    bus.src_tdata  = '0;
    bus.src_tlast  = 1'b0;
    bus.ss_tready  = 1'b0;
    repeat (2) @(posedge axis_clk);
    #1;
    check_reset_state();
    @(negedge axis_clk);
    axis_rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
